// File: rtl/fractal_sync_pkg.sv
// Shared helpers for the fractal sync network: index width and round-robin pointer advance.
// Request types are passed into modules as type parameters, so no typedefs live here.
package fractal_sync_pkg;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Next round-robin position after granting port ptr, wrapping at n.
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
    return (ptr + 1 >= n) ? 32'd0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fractal_sync_rr_arb.sv
// Combinational rotate-priority picker: first set request at or after i_ptr, wrapping.
// Purely combinational; the pointer itself is owned by the caller.
module fractal_sync_rr_arb
  import fractal_sync_pkg::*;
#(
  parameter  int unsigned N     = 4,
  localparam int unsigned IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_gnt,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  logic [2*N-1:0]   w_dbl;
  logic [N-1:0]     w_rot;
  logic [IDX_W-1:0] w_first;
  logic [IDX_W:0]   w_sum;

  // Bit k of the rotated vector is the request of port (ptr + k) mod N.
  assign w_dbl = {i_req, i_req} >> i_ptr;
  assign w_rot = w_dbl[N-1:0];
  assign o_any = |i_req;

  always_comb begin
    w_first = '0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      if (w_rot[k]) w_first = IDX_W'(k);
    end
  end

  assign w_sum = {1'b0, i_ptr} + {1'b0, w_first};

  always_comb begin
    o_idx = w_sum[IDX_W-1:0];
    if (w_sum >= (IDX_W+1)'(N)) o_idx = IDX_W'(w_sum - (IDX_W+1)'(N));
  end

  always_comb begin
    o_gnt = '0;
    for (int i = 0; i < int'(N); i++) begin
      o_gnt[i] = o_any && (o_idx == IDX_W'(i));
    end
  end

endmodule

// File: rtl/fractal_sync_rx_arbiter.sv
// Round-robin arbiter sharing one upstream valid/ready path among N_RX rx request FIFOs.
// Pops the winning FIFO head into a one-entry output register; 1 request/cycle when ready.
module fractal_sync_rx_arbiter
  import fractal_sync_pkg::*;
#(
  parameter  type         fsync_req_t = logic,
  parameter  int unsigned N_RX        = 4,
  localparam int unsigned IDX_W       = idx_width(N_RX)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic       [N_RX-1:0]   empty_i,
  input  fsync_req_t [N_RX-1:0]   req_i,
  output logic       [N_RX-1:0]   pop_o,
  output logic                    valid_o,
  output fsync_req_t              req_o,
  input  logic                    ready_i,
  output logic       [IDX_W-1:0]  grant_idx_o,
  output logic                    busy_o
);

  logic             r_valid;
  fsync_req_t       r_req;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] r_ptr;

  logic [N_RX-1:0]  w_gnt;
  logic [IDX_W-1:0] w_idx;
  logic             w_any;
  logic             w_load;

  fractal_sync_rr_arb #(
    .N (N_RX)
  ) u_rr_arb (
    .i_req (~empty_i),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  // Register is free when empty or being drained this cycle.
  assign w_load = (~r_valid | ready_i) & w_any;
  assign pop_o  = (w_load & rst_ni) ? w_gnt : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= 1'b0;
      r_req   <= '0;
      r_idx   <= '0;
      r_ptr   <= '0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_req   <= req_i[w_idx];
      r_idx   <= w_idx;
      r_ptr   <= IDX_W'(rr_next(32'(w_idx), N_RX));
    end else if (ready_i) begin
      r_valid <= 1'b0;
    end
  end

  assign valid_o     = r_valid;
  assign req_o       = r_req;
  assign grant_idx_o = r_idx;
  assign busy_o      = r_valid | w_any;

  a_pop_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(pop_o));
  a_pop_nonempty: assert property (@(posedge clk_i) disable iff (!rst_ni) (pop_o & empty_i) == '0);
  a_hold_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (r_valid && !ready_i) |=> (r_valid && $stable(r_req) && $stable(r_idx)));

endmodule

// File: tb/tb_fractal_sync_rx_arbiter.sv
// Self-checking bench: TB-owned FIFO queues plus a queue-level round-robin reference model.
module tb_fractal_sync_rx_arbiter;

  localparam int N = 4;

  typedef struct packed {
    logic [2:0] aggr;
    logic [7:0] id;
  } sig_t;

  typedef struct packed {
    logic sync;
    sig_t sig;
  } req_t;

  logic           clk_i;
  logic           rst_ni;
  logic [N-1:0]   empty_i;
  req_t [N-1:0]   req_i;
  logic [N-1:0]   pop_o;
  logic           valid_o;
  req_t           req_o;
  logic           ready_i;
  logic [1:0]     grant_idx_o;
  logic           busy_o;

  fractal_sync_rx_arbiter #(
    .fsync_req_t (req_t),
    .N_RX        (N)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .empty_i     (empty_i),
    .req_i       (req_i),
    .pop_o       (pop_o),
    .valid_o     (valid_o),
    .req_o       (req_o),
    .ready_i     (ready_i),
    .grant_idx_o (grant_idx_o),
    .busy_o      (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  req_t  fq[N][$];
  int    g_log[$];
  int    m_ptr;
  bit    m_valid;
  req_t  m_req;
  int    m_idx;
  int    n_cmp;
  int    n_mis;
  bit    obs_valid;
  req_t  obs_req;
  logic [N-1:0] obs_pop;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic drive_fifo();
    for (int i = 0; i < N; i++) begin
      empty_i[i] = (fq[i].size() == 0);
      req_i[i]   = (fq[i].size() == 0) ? req_t'(12'h0) : fq[i][0];
    end
  endtask

  task automatic model_reset();
    m_ptr   = 0;
    m_valid = 1'b0;
    m_req   = '0;
    m_idx   = 0;
  endtask

  function automatic req_t rand_req();
    logic [11:0] v;
    v = 12'($urandom);
    return v;
  endfunction

  // One clock cycle: drive, check against the model, then advance the model at the edge.
  task automatic step(input bit rdy);
    bit any;
    bit load;
    int w;
    int exp_pop;
    @(negedge clk_i);
    ready_i = rdy;
    drive_fifo();
    #1;
    any = 1'b0;
    for (int i = 0; i < N; i++) if (fq[i].size() > 0) any = 1'b1;
    load = (!m_valid || rdy) && any;
    w = -1;
    if (load) begin
      for (int k = 0; k < N; k++) begin
        int p;
        p = (m_ptr + k) % N;
        if (w < 0 && fq[p].size() > 0) w = p;
      end
    end
    exp_pop = load ? (1 << w) : 0;
    obs_valid = valid_o;
    obs_req   = req_o;
    obs_pop   = pop_o;
    chk_eq("pop_o", 32'(pop_o), exp_pop);
    chk_eq("valid_o", 32'(valid_o), 32'(m_valid));
    chk_eq("req_o", 32'({req_o}), 32'({m_req}));
    chk_eq("grant_idx_o", 32'(grant_idx_o), m_idx);
    chk_eq("busy_o", 32'(busy_o), 32'(m_valid || any));
    @(posedge clk_i);
    if (load) begin
      m_req   = fq[w].pop_front();
      m_idx   = w;
      m_valid = 1'b1;
      m_ptr   = (w + 1) % N;
      g_log.push_back(w);
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
  endtask

  initial begin
    int cnt;
    req_t pass;
    n_cmp   = 0;
    n_mis   = 0;
    rst_ni  = 1'b0;
    ready_i = 1'b0;
    empty_i = '1;
    req_i   = '0;
    model_reset();

    // Reset: no pop even with a non-empty FIFO, registers cleared.
    @(negedge clk_i);
    fq[1].push_back(rand_req());
    drive_fifo();
    #1;
    chk_eq("rst_pop", 32'(pop_o), 0);
    chk_eq("rst_valid", 32'(valid_o), 0);
    fq[1].delete();
    @(negedge clk_i);
    drive_fifo();
    #1;
    chk_eq("rst_busy", 32'(busy_o), 0);
    chk_eq("rst_req", 32'({req_o}), 0);
    chk_eq("rst_idx", 32'(grant_idx_o), 0);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    for (int c = 0; c < 10; c++) step(1'b0);

    // Fairness: 3 entries per port, ready always high.
    g_log.delete();
    for (int i = 0; i < N; i++) for (int j = 0; j < 3; j++) fq[i].push_back(rand_req());
    cnt = 0;
    for (int c = 0; c < 14; c++) begin
      step(1'b1);
      if (obs_valid) cnt++;
    end
    chk_eq("fair_valid_cycles", cnt, 12);
    chk_eq("fair_grants", g_log.size(), 12);
    for (int k = 0; k < 12 && k < g_log.size(); k++) chk_eq("fair_order", g_log[k], k % 4);

    // Backpressure on port 2; port 1 arrives while stalled.
    g_log.delete();
    fq[2].push_back(rand_req());
    cnt = 0;
    step(1'b0);
    if (obs_pop[2]) cnt++;
    fq[1].push_back(rand_req());
    for (int c = 0; c < 5; c++) begin
      step(1'b0);
      if (obs_pop[2]) cnt++;
      chk_eq("bp_valid_held", 32'(obs_valid), 1);
    end
    chk_eq("bp_single_pop", cnt, 1);

    // Skip + wrap: ptr at 3 with only port 1 pending, then ports 0 and 3.
    step(1'b1);
    fq[0].push_back(rand_req());
    fq[3].push_back(rand_req());
    for (int c = 0; c < 4; c++) step(1'b1);
    chk_eq("skip_grants", g_log.size(), 4);
    if (g_log.size() == 4) begin
      chk_eq("skip_g0", g_log[0], 2);
      chk_eq("skip_g1", g_log[1], 1);
      chk_eq("skip_g2", g_log[2], 3);
      chk_eq("skip_g3", g_log[3], 0);
    end

    // Passthrough of a fixed request, then drain.
    pass.sync     = 1'b1;
    pass.sig.aggr = 3'b101;
    pass.sig.id   = 8'd7;
    fq[1].push_back(pass);
    step(1'b1);
    step(1'b1);
    chk_eq("pass_valid", 32'(obs_valid), 1);
    chk_eq("pass_req", 32'({obs_req}), 32'({pass}));
    step(1'b1);
    chk_eq("pass_drain", 32'(obs_valid), 0);

    // Reset while a request is stalled.
    fq[2].push_back(rand_req());
    step(1'b0);
    fq[0].push_back(rand_req());
    fq[3].push_back(rand_req());
    step(1'b0);
    #2 rst_ni = 1'b0;
    #1;
    chk_eq("midrst_valid", 32'(valid_o), 0);
    chk_eq("midrst_pop", 32'(pop_o), 0);
    model_reset();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk_i);
      drive_fifo();
      #1;
      chk_eq("midrst_hold_pop", 32'(pop_o), 0);
    end
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    g_log.delete();
    step(1'b1);
    step(1'b1);
    step(1'b1);
    chk_eq("midrst_grants", g_log.size(), 2);
    if (g_log.size() == 2) begin
      chk_eq("midrst_first", g_log[0], 0);
      chk_eq("midrst_second", g_log[1], 3);
    end

    // Randomized traffic with periodic stall bursts.
    for (int c = 0; c < 600; c++) begin
      bit rdy;
      for (int p = 0; p < N; p++) begin
        if ($urandom_range(0, 3) == 0 && fq[p].size() < 4) fq[p].push_back(rand_req());
      end
      rdy = ((c % 50) < 6) ? 1'b0 : ($urandom_range(0, 2) != 0);
      step(rdy);
    end
    for (int c = 0; c < 24; c++) step(1'b1);
    chk_eq("final_idle", 32'(busy_o), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
